// File: rtl/cnn_run_sequencer_pkg.sv
// Shared types and defaults for the CNN run sequencer and its neighbours.
package cnn_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } seq_state_e;

  localparam int CNN_DATA_WIDTH         = 160;
  localparam int DEFAULT_TIMEOUT_CYCLES = 4096;
  localparam int DEFAULT_COUNT_WIDTH    = 16;

endpackage

// File: rtl/cnn_run_sequencer_if.sv
// Core-side start/valid/data and downstream valid/ready result channel.
interface cnn_run_sequencer_if
  import cnn_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = CNN_DATA_WIDTH
) ();

  logic                  cnn_start_o;
  logic                  cnn_valid_i;
  logic [DATA_WIDTH-1:0] cnn_data_i;
  logic                  result_valid_o;
  logic [DATA_WIDTH-1:0] result_data_o;
  logic                  result_ready_i;

  modport master (
    output cnn_start_o, result_valid_o, result_data_o,
    input  cnn_valid_i, cnn_data_i, result_ready_i
  );

  modport slave (
    input  cnn_start_o, result_valid_o, result_data_o,
    output cnn_valid_i, cnn_data_i, result_ready_i
  );

endinterface

// File: rtl/cnn_run_sequencer_rise_detect.sv
// Registered 0->1 edge detector; stays disarmed for the first cycle after
// reset so a level already high at reset release is not seen as a rise.
module rise_detect (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q_r;
  logic armed_r;

  // previous-level register and post-reset arming flag
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sig_q_r <= 1'b0;
      armed_r <= 1'b0;
    end else begin
      sig_q_r <= sig_i;
      armed_r <= 1'b1;
    end
  end

  assign rise_o = armed_r & sig_i & ~sig_q_r;

endmodule

// File: rtl/cnn_run_sequencer.sv
// One CNN inference run per begin_i rise: start pulse, wait for valid or
// timeout, then hold the captured score vector until downstream accepts it.
module cnn_run_sequencer
  import cnn_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = CNN_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int COUNT_WIDTH    = DEFAULT_COUNT_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   begin_i,
  cnn_run_sequencer_if.master    bus,
  output logic                   busy_o,
  output logic                   timeout_o,
  output logic [COUNT_WIDTH-1:0] run_count_o,
  output logic [COUNT_WIDTH-1:0] err_count_o
);

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  seq_state_e             state_r, state_s;
  logic                   pending_r, pending_s;
  logic [15:0]            wait_cnt_r, wait_cnt_s;
  logic                   start_r, start_s;
  logic                   result_valid_r, result_valid_s;
  logic [DATA_WIDTH-1:0]  result_data_r, result_data_s;
  logic                   busy_r, busy_s;
  logic                   timeout_r, timeout_s;
  logic [COUNT_WIDTH-1:0] run_count_r, run_count_s;
  logic [COUNT_WIDTH-1:0] err_count_r, err_count_s;
  logic                   rise_s;

  rise_detect u_begin_rise (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .sig_i   (begin_i),
    .rise_o  (rise_s)
  );

  // next-state and next-output decode; every output is a flop fed from here
  always_comb begin
    state_s        = state_r;
    pending_s      = pending_r | rise_s;
    wait_cnt_s     = wait_cnt_r;
    result_valid_s = result_valid_r;
    result_data_s  = result_data_r;
    timeout_s      = 1'b0;
    run_count_s    = run_count_r;
    err_count_s    = err_count_r;
    case (state_r)
      IDLE: begin
        if (rise_s || pending_r) begin
          state_s   = START;
          // a rise landing as pending is consumed counts as a new request
          pending_s = pending_r & rise_s;
        end else begin
          state_s   = IDLE;
          pending_s = pending_r;
        end
      end
      START: begin
        wait_cnt_s = 16'd0;
        state_s    = WAIT;
      end
      WAIT: begin
        wait_cnt_s = wait_cnt_r + 16'd1;
        if (bus.cnn_valid_i) begin
          result_data_s  = bus.cnn_data_i;
          result_valid_s = 1'b1;
          run_count_s    = run_count_r + COUNT_WIDTH'(1);
          state_s        = HOLD;
        end else if (wait_cnt_r == WAIT_LAST) begin
          timeout_s = 1'b1;
          if (err_count_r != {COUNT_WIDTH{1'b1}}) begin
            err_count_s = err_count_r + COUNT_WIDTH'(1);
          end else begin
            err_count_s = err_count_r;
          end
          state_s = IDLE;
        end else begin
          state_s = WAIT;
        end
      end
      HOLD: begin
        if (bus.result_ready_i) begin
          result_valid_s = 1'b0;
          state_s        = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    start_s = (state_s == START);
    busy_s  = (state_s != IDLE);
  end

  // state and output registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r        <= IDLE;
      pending_r      <= 1'b0;
      wait_cnt_r     <= 16'd0;
      start_r        <= 1'b0;
      result_valid_r <= 1'b0;
      result_data_r  <= '0;
      busy_r         <= 1'b0;
      timeout_r      <= 1'b0;
      run_count_r    <= '0;
      err_count_r    <= '0;
    end else begin
      state_r        <= state_s;
      pending_r      <= pending_s;
      wait_cnt_r     <= wait_cnt_s;
      start_r        <= start_s;
      result_valid_r <= result_valid_s;
      result_data_r  <= result_data_s;
      busy_r         <= busy_s;
      timeout_r      <= timeout_s;
      run_count_r    <= run_count_s;
      err_count_r    <= err_count_s;
    end
  end

  assign bus.cnn_start_o    = start_r;
  assign bus.result_valid_o = result_valid_r;
  assign bus.result_data_o  = result_data_r;
  assign busy_o             = busy_r;
  assign timeout_o          = timeout_r;
  assign run_count_o        = run_count_r;
  assign err_count_o        = err_count_r;

endmodule

// File: tb/tb_cnn_run_sequencer.sv
// Directed bench: default-timeout instance for runs/back-pressure/pending/reset,
// an 8-cycle-timeout instance for timeout and valid/timeout coincidence.
module tb_cnn_run_sequencer;
  import cnn_ctrl_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        begin_i;
  logic        busy_a, timeout_a, busy_t, timeout_t;
  logic [15:0] run_a, err_a, run_t, err_t;
  int          n_assert = 0;
  int          n_fail   = 0;
  int          start_a  = 0;
  int          start_t  = 0;
  int          base_cnt;

  localparam logic [159:0] D1 = 160'h0123456789ABCDEF0123456789ABCDEF89ABCDEF;
  localparam logic [159:0] D2 = 160'hDEADBEEF00112233445566778899AABBCCDDEEFF;
  localparam logic [159:0] D3 = 160'hFFFFFFFF0000000055555555AAAAAAAA12345678;
  localparam logic [159:0] D4 = 160'h00000000000000000000000000000000CAFEF00D;
  localparam logic [159:0] D5 = 160'h5A5A5A5AA5A5A5A5F0F0F0F00F0F0F0F13579BDF;

  cnn_run_sequencer_if #(.DATA_WIDTH(160)) bus_a ();
  cnn_run_sequencer_if #(.DATA_WIDTH(160)) bus_t ();

  always #5 clk_i = ~clk_i;

  cnn_run_sequencer #(.DATA_WIDTH(160), .TIMEOUT_CYCLES(4096), .COUNT_WIDTH(16)) dut_a (
    .clk_i(clk_i), .reset_i(reset_i), .begin_i(begin_i), .bus(bus_a),
    .busy_o(busy_a), .timeout_o(timeout_a), .run_count_o(run_a), .err_count_o(err_a)
  );

  cnn_run_sequencer #(.DATA_WIDTH(160), .TIMEOUT_CYCLES(8), .COUNT_WIDTH(16)) dut_t (
    .clk_i(clk_i), .reset_i(reset_i), .begin_i(begin_i), .bus(bus_t),
    .busy_o(busy_t), .timeout_o(timeout_t), .run_count_o(run_t), .err_count_o(err_t)
  );

  always @(negedge clk_i) begin
    if (bus_a.cnn_start_o === 1'b1) start_a++;
    if (bus_t.cnn_start_o === 1'b1) start_t++;
  end

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_run(input logic [159:0] d, input int lat);
    begin_i = 1'b1;
    @(negedge clk_i);
    begin_i = 1'b0;
    repeat (lat) @(negedge clk_i);
    bus_a.cnn_valid_i = 1'b1;
    bus_a.cnn_data_i  = d;
    @(negedge clk_i);
    bus_a.cnn_valid_i = 1'b0;
    chk("loop_data", bus_a.result_data_o, d);
    @(negedge clk_i);
  endtask

  initial begin
    reset_i = 1'b1;
    begin_i = 1'b0;
    bus_a.cnn_valid_i = 1'b0; bus_a.cnn_data_i = '0; bus_a.result_ready_i = 1'b0;
    bus_t.cnn_valid_i = 1'b0; bus_t.cnn_data_i = '0; bus_t.result_ready_i = 1'b0;
    repeat (16) @(negedge clk_i);
    chk("rst_busy",   160'(busy_a), 160'd0);
    chk("rst_start",  160'(bus_a.cnn_start_o), 160'd0);
    chk("rst_rvalid", 160'(bus_a.result_valid_o), 160'd0);
    chk("rst_data",   bus_a.result_data_o, 160'd0);
    chk("rst_counts", 160'({run_a, err_a}), 160'd0);
    chk("rst_tmo",    160'(timeout_a), 160'd0);
    reset_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // basic run, begin held 20 cycles, core answers 50 cycles after start
    bus_a.result_ready_i = 1'b1;
    begin_i = 1'b1;
    @(negedge clk_i);
    chk("basic_start", 160'(bus_a.cnn_start_o), 160'd1);
    chk("basic_busy",  160'(busy_a), 160'd1);
    repeat (19) @(negedge clk_i);
    begin_i = 1'b0;
    repeat (31) @(negedge clk_i);
    bus_a.cnn_valid_i = 1'b1;
    bus_a.cnn_data_i  = D1;
    @(negedge clk_i);
    bus_a.cnn_valid_i = 1'b0;
    chk("basic_rvalid", 160'(bus_a.result_valid_o), 160'd1);
    chk("basic_data",   bus_a.result_data_o, D1);
    chk("basic_run",    160'(run_a), 160'd1);
    chk("basic_tmo",    160'(timeout_a), 160'd0);
    @(negedge clk_i);
    chk("basic_rvalid_clr", 160'(bus_a.result_valid_o), 160'd0);
    chk("basic_busy_clr",   160'(busy_a), 160'd0);
    chk("basic_one_start",  160'(start_a), 160'd1);

    // valid while idle is ignored
    bus_a.cnn_valid_i = 1'b1;
    bus_a.cnn_data_i  = D3;
    @(negedge clk_i);
    bus_a.cnn_valid_i = 1'b0;
    @(negedge clk_i);
    chk("idle_valid_rvalid", 160'(bus_a.result_valid_o), 160'd0);
    chk("idle_valid_data",   bus_a.result_data_o, D1);

    // back-pressure
    bus_a.result_ready_i = 1'b0;
    begin_i = 1'b1;
    @(negedge clk_i);
    begin_i = 1'b0;
    repeat (5) @(negedge clk_i);
    bus_a.cnn_valid_i = 1'b1;
    bus_a.cnn_data_i  = D2;
    @(negedge clk_i);
    bus_a.cnn_valid_i = 1'b0;
    chk("bp_rvalid", 160'(bus_a.result_valid_o), 160'd1);
    chk("bp_data",   bus_a.result_data_o, D2);
    repeat (10) @(negedge clk_i);
    bus_a.cnn_valid_i = 1'b1;
    bus_a.cnn_data_i  = D3;
    @(negedge clk_i);
    bus_a.cnn_valid_i = 1'b0;
    repeat (19) @(negedge clk_i);
    chk("bp_hold_data",   bus_a.result_data_o, D2);
    chk("bp_hold_rvalid", 160'(bus_a.result_valid_o), 160'd1);
    chk("bp_hold_busy",   160'(busy_a), 160'd1);
    chk("bp_run",         160'(run_a), 160'd2);
    bus_a.result_ready_i = 1'b1;
    @(negedge clk_i);
    chk("bp_accept_rvalid", 160'(bus_a.result_valid_o), 160'd0);
    chk("bp_accept_busy",   160'(busy_a), 160'd0);

    // pending request: three rises during WAIT collapse to one extra run
    begin_i = 1'b1;
    @(negedge clk_i);
    begin_i = 1'b0;
    @(negedge clk_i);
    begin_i = 1'b1; @(negedge clk_i);
    begin_i = 1'b0; @(negedge clk_i);
    begin_i = 1'b1; @(negedge clk_i);
    begin_i = 1'b0; @(negedge clk_i);
    begin_i = 1'b1; @(negedge clk_i);
    begin_i = 1'b0;
    repeat (3) @(negedge clk_i);
    bus_a.cnn_valid_i = 1'b1;
    bus_a.cnn_data_i  = D4;
    @(negedge clk_i);
    bus_a.cnn_valid_i = 1'b0;
    chk("pend_rvalid", 160'(bus_a.result_valid_o), 160'd1);
    chk("pend_run",    160'(run_a), 160'd3);
    @(negedge clk_i);
    chk("pend_idle_busy",  160'(busy_a), 160'd0);
    chk("pend_idle_start", 160'(bus_a.cnn_start_o), 160'd0);
    @(negedge clk_i);
    chk("pend_start", 160'(bus_a.cnn_start_o), 160'd1);
    repeat (4) @(negedge clk_i);
    bus_a.cnn_valid_i = 1'b1;
    bus_a.cnn_data_i  = D1;
    @(negedge clk_i);
    bus_a.cnn_valid_i = 1'b0;
    @(negedge clk_i);
    chk("pend_run2",   160'(run_a), 160'd4);
    chk("pend_starts", 160'(start_a), 160'd4);
    for (int i = 0; i < 6; i++) begin
      do_run(D1 ^ 160'(i), 3 + i);
    end
    chk("ten_runs",   160'(run_a), 160'd10);
    chk("ten_starts", 160'(start_a), 160'd10);
    chk("ten_err",    160'(err_a), 160'd0);

    // timeout on the 8-cycle instance, core never answers
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    repeat (2) @(negedge clk_i);
    begin_i = 1'b1;
    @(negedge clk_i);
    chk("tmo_start", 160'(bus_t.cnn_start_o), 160'd1);
    repeat (8) @(negedge clk_i);
    chk("tmo_pre_pulse", 160'(timeout_t), 160'd0);
    chk("tmo_pre_busy",  160'(busy_t), 160'd1);
    @(negedge clk_i);
    chk("tmo_pulse",  160'(timeout_t), 160'd1);
    chk("tmo_busy",   160'(busy_t), 160'd0);
    chk("tmo_err",    160'(err_t), 160'd1);
    chk("tmo_run",    160'(run_t), 160'd0);
    chk("tmo_rvalid", 160'(bus_t.result_valid_o), 160'd0);
    @(negedge clk_i);
    chk("tmo_one_cycle", 160'(timeout_t), 160'd0);
    chk("tmo_no_retrig", 160'(busy_t), 160'd0);
    begin_i = 1'b0;
    @(negedge clk_i);

    // valid arriving on the last WAIT cycle beats the timeout
    begin_i = 1'b1;
    @(negedge clk_i);
    begin_i = 1'b0;
    repeat (8) @(negedge clk_i);
    bus_t.cnn_valid_i = 1'b1;
    bus_t.cnn_data_i  = D5;
    @(negedge clk_i);
    bus_t.cnn_valid_i = 1'b0;
    chk("co_rvalid", 160'(bus_t.result_valid_o), 160'd1);
    chk("co_data",   bus_t.result_data_o, D5);
    chk("co_tmo",    160'(timeout_t), 160'd0);
    chk("co_err",    160'(err_t), 160'd1);
    chk("co_run",    160'(run_t), 160'd1);
    bus_t.result_ready_i = 1'b1;
    @(negedge clk_i);
    chk("co_accept_busy", 160'(busy_t), 160'd0);

    // reset mid-run with begin held high
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    repeat (2) @(negedge clk_i);
    begin_i = 1'b1;
    @(negedge clk_i);
    repeat (3) @(negedge clk_i);
    chk("mid_busy", 160'(busy_a), 160'd1);
    reset_i = 1'b1;
    @(negedge clk_i);
    chk("mid_rst_busy",   160'(busy_a), 160'd0);
    chk("mid_rst_start",  160'(bus_a.cnn_start_o), 160'd0);
    chk("mid_rst_rvalid", 160'(bus_a.result_valid_o), 160'd0);
    chk("mid_rst_tmo",    160'(timeout_a), 160'd0);
    base_cnt = start_a;
    reset_i = 1'b0;
    repeat (10) @(negedge clk_i);
    chk("mid_no_start", 160'(start_a - base_cnt), 160'd0);
    chk("mid_idle",     160'(busy_a), 160'd0);
    begin_i = 1'b0;
    repeat (2) @(negedge clk_i);
    begin_i = 1'b1;
    @(negedge clk_i);
    chk("mid_restart", 160'(bus_a.cnn_start_o), 160'd1);
    repeat (2) @(negedge clk_i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cnn_run_sequencer.md
Name: cnn_run_sequencer

Overview:
- Sequences one inference run of the CNN core per rising edge of the top-level begin request.
- Pulses the core's start, waits for the core's valid strobe, and captures the 160-bit class-score vector.
- Presents the captured vector downstream on a valid/ready interface.
- Sits in the top level between the begin input and the CNN core, on the core's clock domain, after the clock and reset generators.

Parameters:
- DATA_WIDTH, 160, width of the CNN output vector.
- TIMEOUT_CYCLES, 4096, maximum cycles spent in WAIT before a run is aborted; legal range 2..65535.
- COUNT_WIDTH, 16, width of the run and error counters.

Ports:
- clk_i  in  1  core clock.
- reset_i  in  1  asynchronous, active-high reset.
- begin_i  in  1  run request level; a run is triggered on each 0->1 transition.
- cnn_start_o  out  1  one-cycle start pulse to the CNN core.
- cnn_valid_i  in  1  one-cycle strobe from the core; cnn_data_i is valid in that cycle.
- cnn_data_i  in  DATA_WIDTH  CNN output vector.
- result_valid_o  out  1  captured result available.
- result_data_o  out  DATA_WIDTH  captured result.
- result_ready_i  in  1  downstream accepts the result when high together with result_valid_o.
- busy_o  out  1  high whenever the state is not IDLE.
- timeout_o  out  1  one-cycle pulse when a run is aborted.
- run_count_o  out  COUNT_WIDTH  completed runs; wraps at 2^COUNT_WIDTH.
- err_count_o  out  COUNT_WIDTH  aborted runs; saturates at all-ones.

Behaviour:
- Reset (asynchronous assert, all registers): state=IDLE, every output=0, result_data_o=0, begin_q=0, pending=0, wait counter=0.
- Edge detect: begin_q registers begin_i. A rise is begin_i & ~begin_q. A level held high never retriggers.
- Reset mid-run: all of the above is cleared immediately. A begin_i already high at reset release does not fire until it drops and rises again, because begin_q is loaded with begin_i in the first post-reset cycle.
- IDLE:
  - On a rise or pending=1, go to START and clear pending.
  - cnn_valid_i is ignored.
- START:
  - cnn_start_o=1 for exactly this cycle; clear the wait counter; go to WAIT.
  - Latency: a rise sampled at edge n gives cnn_start_o high in cycle n+1.
- WAIT:
  - The wait counter increments each cycle.
  - On cnn_valid_i: capture cnn_data_i into result_data_o, increment run_count_o, set result_valid_o, go to HOLD. Latency from the strobe is 1 cycle.
  - Else, if the counter equals TIMEOUT_CYCLES-1: pulse timeout_o, increment err_count_o (saturating), go to IDLE, leave result_data_o unchanged.
  - If valid and timeout fall in the same cycle, valid wins and timeout_o stays 0.
- HOLD:
  - result_valid_o=1 and result_data_o stays stable until result_ready_i=1.
  - On the accept cycle, clear result_valid_o and go to IDLE. If pending=1, IDLE leaves for START on the next cycle.
  - cnn_valid_i is ignored, so the held data is never overwritten.
- Pending request:
  - A rise seen in START, WAIT or HOLD sets pending (one deep); further rises while pending=1 are dropped.
  - A rise in the same cycle that IDLE consumes pending is treated as new: pending stays set.
- busy_o = (state != IDLE), registered with the state.
- All outputs are driven from flops; no combinational path from an input to an output.

Decomposition:
- Shared package cnn_ctrl_pkg holds:
  - the state enum (IDLE, START, WAIT, HOLD) as a 2-bit typedef;
  - CNN_DATA_WIDTH=160;
  - the default TIMEOUT_CYCLES.
- One natural sub-module, rise_detect: a 1-bit registered edge detector with asynchronous reset. It is reusable for other top-level control inputs.

Test Plan:
- Basic run: reset 16 cycles, raise begin_i and hold it 20 cycles; the model core asserts cnn_valid_i with data 160'h0123...CDEF 50 cycles after the start pulse.
  -> Exactly one cnn_start_o pulse; result_valid_o rises 1 cycle after valid with matching data; run_count_o=1; with result_ready_i=1, busy_o falls the cycle after accept.
- Back-pressure: hold result_ready_i=0 for 30 cycles, pulse cnn_valid_i with different data during HOLD.
  -> result_data_o unchanged, result_valid_o stays 1; one accept returns the FSM to IDLE.
- Timeout: TIMEOUT_CYCLES=8, model core never responds.
  -> timeout_o pulses in the 8th WAIT cycle; err_count_o=1; run_count_o=0; state returns to IDLE; result_valid_o never asserts.
- Valid and timeout coincident: TIMEOUT_CYCLES=8, valid on the 8th WAIT cycle.
  -> Result captured, timeout_o=0, err_count_o unchanged.
- Pending request: toggle begin_i 0->1->0->1->0->1 during WAIT.
  -> Exactly one extra cnn_start_o, issued 2 cycles after the first run's accept; 10 runs in total give run_count_o=10.
- Reset mid-run: assert reset_i in WAIT with begin_i held high, then release.
  -> All outputs 0 during reset; no cnn_start_o until begin_i falls and rises again.
